// File: rtl/atm_account_core.sv
// Account database and transaction engine for the ATM controller.
// Combinational lookup and authentication; one registered transaction per op_valid strobe.
module atm_account_core #(
  parameter int NUM_ACCOUNTS = 10,
  parameter int DW           = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic [2:0]    operation,
  input  logic [3:0]    acc_num,
  input  logic [DW-1:0] pin,
  input  logic [DW-1:0] new_pin,
  input  logic [DW-1:0] amount,
  output logic [3:0]    acc_index,
  output logic          acc_found,
  output logic          acc_auth,
  output logic [DW-1:0] balance,
  output logic          success,
  output logic          done
);

  typedef enum logic [2:0] {
    OP_BALANCE    = 3'd3,
    OP_WITHDRAW   = 3'd4,
    OP_DEPOSIT    = 3'd5,
    OP_CHANGE_PIN = 3'd6
  } op_e;

  localparam logic [DW-1:0] PIN_MAX = DW'(9999);
  localparam logic [DW:0]   BAL_MAX = {1'b0, {DW{1'b1}}};

  logic [DW-1:0] pin_mem [NUM_ACCOUNTS];
  logic [DW-1:0] bal_mem [NUM_ACCOUNTS];

  logic [DW-1:0] cur_pin;
  logic [DW-1:0] cur_bal;
  logic [DW:0]   sum;
  logic [DW-1:0] new_bal;
  logic          wr_bal;
  logic          wr_pin;
  logic          nxt_success;
  logic [DW-1:0] nxt_balance;

  // Account numbers are fixed at index+1, so they need no storage.
  always_comb begin
    acc_index = '1;
    acc_found = 1'b0;
    cur_pin   = '0;
    cur_bal   = '0;
    for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
      if (acc_num == 4'(i + 1)) begin
        acc_index = 4'(i);
        acc_found = 1'b1;
        cur_pin   = pin_mem[i];
        cur_bal   = bal_mem[i];
      end
    end
    acc_auth = acc_found && (pin == cur_pin);
  end

  always_comb begin
    sum         = {1'b0, cur_bal} + {1'b0, amount};
    new_bal     = cur_bal;
    wr_bal      = 1'b0;
    wr_pin      = 1'b0;
    nxt_success = 1'b0;
    nxt_balance = '0;
    if (acc_auth) begin
      nxt_balance = cur_bal;
      case (op_e'(operation))
        OP_BALANCE: nxt_success = 1'b1;
        OP_WITHDRAW: begin
          if (amount <= cur_bal) begin
            new_bal     = cur_bal - amount;
            nxt_balance = new_bal;
            wr_bal      = 1'b1;
            nxt_success = 1'b1;
          end
        end
        OP_DEPOSIT: begin
          if (sum <= BAL_MAX) begin
            new_bal     = sum[DW-1:0];
            nxt_balance = new_bal;
            wr_bal      = 1'b1;
            nxt_success = 1'b1;
          end
        end
        OP_CHANGE_PIN: begin
          if (new_pin <= PIN_MAX) begin
            wr_pin      = 1'b1;
            nxt_success = 1'b1;
          end
        end
        default: nxt_success = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
        pin_mem[i] <= DW'(1000 + i);
        bal_mem[i] <= DW'(500 * (i + 1));
      end
      balance <= '0;
      success <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= op_valid;
      if (op_valid) begin
        balance <= nxt_balance;
        success <= nxt_success;
        for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
          if (acc_index == 4'(i)) begin
            if (wr_bal) bal_mem[i] <= new_bal;
            if (wr_pin) pin_mem[i] <= new_pin;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_atm_account_core.sv
// Directed and randomized checks of atm_account_core against an array-based account model.
module tb_atm_account_core;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic [2:0]    operation;
  logic [3:0]    acc_num;
  logic [DW-1:0] pin;
  logic [DW-1:0] new_pin;
  logic [DW-1:0] amount;
  logic [3:0]    acc_index;
  logic          acc_found;
  logic          acc_auth;
  logic [DW-1:0] balance;
  logic          success;
  logic          done;

  int vectors    = 0;
  int miscompares = 0;
  int m_pin [10];
  int m_bal [10];
  int last_s = 0;
  int last_b = 0;

  atm_account_core #(.NUM_ACCOUNTS(10), .DW(DW)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .operation(operation),
    .acc_num(acc_num), .pin(pin), .new_pin(new_pin), .amount(amount),
    .acc_index(acc_index), .acc_found(acc_found), .acc_auth(acc_auth),
    .balance(balance), .success(success), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      m_pin[i] = 1000 + i;
      m_bal[i] = 500 * (i + 1);
    end
    last_s = 0;
    last_b = 0;
  endtask

  // Presents one transaction, checks lookup before the edge and results after it.
  task automatic do_op(input int op, input int an, input int p, input int np, input int amt);
    int  idx;
    bit  auth;
    operation = 3'(op);
    acc_num   = 4'(an);
    pin       = DW'(p);
    new_pin   = DW'(np);
    amount    = DW'(amt);
    op_valid  = 1'b1;
    #1;
    idx  = (an >= 1 && an <= 10) ? an - 1 : 15;
    auth = (idx != 15) && (m_pin[idx] == p);
    check("acc_found", 32'(acc_found), 32'(idx != 15));
    check("acc_index", 32'(acc_index), 32'(idx));
    check("acc_auth", 32'(acc_auth), 32'(auth));
    last_s = 0;
    last_b = 0;
    if (auth) begin
      last_b = m_bal[idx];
      case (op)
        3: last_s = 1;
        4: if (amt <= m_bal[idx]) begin m_bal[idx] -= amt; last_s = 1; end
        5: if (m_bal[idx] + amt <= 16383) begin m_bal[idx] += amt; last_s = 1; end
        6: if (np <= 9999) begin m_pin[idx] = np; last_s = 1; end
        default: last_s = 0;
      endcase
      last_b = m_bal[idx];
    end
    @(posedge clk);
    #1;
    check("done_pulse", 32'(done), 32'd1);
    check("success", 32'(success), 32'(last_s));
    check("balance", 32'(balance), 32'(last_b));
  endtask

  task automatic idle();
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    check("done_low", 32'(done), 32'd0);
    check("success_hold", 32'(success), 32'(last_s));
    check("balance_hold", 32'(balance), 32'(last_b));
  endtask

  initial begin
    int an, p, op;
    rst = 1'b0; op_valid = 1'b0; operation = '0; acc_num = '0;
    pin = '0; new_pin = '0; amount = '0;
    model_reset();
    #1;
    check("rst_balance", 32'(balance), 32'd0);
    check("rst_success", 32'(success), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Lookup and balance query
    do_op(3, 3, 1002, 0, 0);
    idle();
    // Withdraw: partial, overdraw, exact
    do_op(4, 3, 1002, 0, 200);
    do_op(4, 3, 1002, 0, 2000);
    do_op(4, 3, 1002, 0, 1300);
    do_op(4, 3, 1002, 0, 0);
    idle();
    // Deposit to ceiling, then overflow
    do_op(5, 10, 1009, 0, 11383);
    do_op(5, 10, 1009, 0, 1);
    // PIN change and its effect on authentication
    do_op(6, 1, 1000, 4321, 0);
    do_op(3, 1, 1000, 0, 0);
    do_op(3, 1, 4321, 0, 0);
    do_op(6, 1, 4321, 12000, 0);
    do_op(6, 1, 4321, 9999, 0);
    do_op(6, 1, 9999, 4321, 0);
    // Unknown accounts
    do_op(3, 0, 1000, 0, 0);
    do_op(5, 12, 1000, 0, 5);
    do_op(4, 15, 0, 0, 0);
    idle();

    // Reset asserted while a strobe is pending
    operation = 3'd5; acc_num = 4'd3; pin = DW'(1002); amount = DW'(100); op_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("mid_rst_balance", 32'(balance), 32'd0);
    check("mid_rst_success", 32'(success), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("held_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b1;
    do_op(3, 1, 1000, 0, 0);
    do_op(3, 3, 1002, 0, 0);
    do_op(7, 3, 1002, 0, 0);
    do_op(0, 3, 1002, 0, 0);
    idle();

    // Randomized traffic, mostly back-to-back
    for (int n = 0; n < 400; n++) begin
      an = $urandom_range(0, 15);
      if (an >= 1 && an <= 10 && $urandom_range(0, 9) < 8) p = m_pin[an - 1];
      else p = $urandom_range(0, 16383);
      op = ($urandom_range(0, 9) < 8) ? $urandom_range(3, 6) : $urandom_range(0, 7);
      do_op(op, an, p, $urandom_range(0, 12000),
            ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3000) : $urandom_range(0, 16383));
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/atm_account_core.md
Name: atm_account_core

Overview:
Account database and transaction engine for the ATM controller. It holds account numbers, PINs and balances for 10 accounts. It performs combinational account lookup and PIN authentication, and executes one registered transaction per strobe: balance query, withdraw, deposit or PIN change. The ATM menu FSM sits above it and drives acc_num/pin continuously, pulsing op_valid when a transaction is selected.

Parameters:
NUM_ACCOUNTS, 10, number of database entries (indices 0..NUM_ACCOUNTS-1)
DW, 14, width of PIN, amount and balance fields

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
op_valid  in  1  transaction strobe, sampled at posedge clk
operation  in  3  3=BALANCE, 4=WITHDRAW, 5=DEPOSIT, 6=CHANGE_PIN; other codes are no-op
acc_num  in  4  account number presented by user
pin  in  DW  PIN presented by user
new_pin  in  DW  replacement PIN for CHANGE_PIN
amount  in  DW  withdraw/deposit amount, unsigned
acc_index  out  4  matching database index; 4'hF when not found
acc_found  out  1  acc_num matches an entry (combinational)
acc_auth  out  1  acc_found AND pin equals stored PIN (combinational)
balance  out  DW  registered post-transaction balance of the addressed account
success  out  1  registered result of last transaction
done  out  1  one-cycle pulse marking a completed transaction

Behaviour:
- Database reset contents for index i (0..9):
  - account number = i+1 (valid numbers 1..10; 0 and 11..15 never match)
  - PIN = 1000+i
  - balance = 500*(i+1)
- rst low (async): database reloads the reset contents; balance=0, success=0, done=0. Any transaction in flight is discarded.
- Lookup is purely combinational from acc_num, pin and current database contents. acc_auth always uses the current stored PIN, so a PIN change takes effect from the cycle after it commits.
- On posedge clk with op_valid=1 (one-cycle latency):
  - done=1 for exactly that cycle; otherwise done=0 and balance/success hold.
  - If acc_auth=0: success=0, balance=0, database unchanged. Balance is never leaked on a failed authentication.
  - BALANCE: success=1, balance=stored balance.
  - WITHDRAW: if amount <= stored balance, then stored balance and balance output = old-amount, success=1. Otherwise success=0, balance output = unchanged stored balance. amount=0 succeeds.
  - DEPOSIT: compute a (DW+1)-bit sum. If sum <= 2^DW-1 (16383), commit it, balance output = sum, success=1. Otherwise success=0, balance output = unchanged stored balance. No wrap-around.
  - CHANGE_PIN: if new_pin <= 9999, store it, success=1. Otherwise success=0 and PIN unchanged. balance output = stored balance in both cases.
  - Invalid operation code: success=0, balance output = stored balance, database unchanged.
- Back-to-back strobes are permitted every cycle. Each strobe sees the database as updated by the previous one.
- Only the addressed entry is ever written; other entries are never disturbed.

Test Plan:
- Reset, then acc_num=3, pin=1002 -> acc_found=1, acc_index=2, acc_auth=1. BALANCE strobe -> next cycle balance=1500, success=1, done pulse of 1 cycle.
- Account 3: WITHDRAW 200 -> balance=1300, success=1. Then WITHDRAW 2000 -> success=0, balance=1300. Then WITHDRAW 1300 -> balance=0, success=1.
- Account 10 (pin 1009, balance 5000): DEPOSIT 11383 -> balance=16383, success=1. Then DEPOSIT 1 -> success=0, balance=16383.
- Account 1: CHANGE_PIN new_pin=4321 -> success=1. Next cycle pin=1000 gives acc_auth=0, and a BALANCE strobe returns success=0, balance=0. pin=4321 gives acc_auth=1. CHANGE_PIN new_pin=12000 -> success=0.
- acc_num=0 and acc_num=12 -> acc_found=0, acc_index=4'hF. Any strobe -> success=0, balance=0, database unchanged.
- Modify accounts 1 and 3, assert rst low mid-strobe -> outputs 0 immediately. After release, account 1 pin=1000 and balance=500, account 3 balance=1500. An operation code of 7 with valid authentication -> success=0, done pulse.
